// File: rtl/alu_instr_sequencer.sv
// Hardwired T-step control sequencer for register-register ALU instructions on the shared-bus datapath.
// Optional SEQ_AUTOFETCH_EN: chain straight into the next fetch when start is held in the last step.
module alu_instr_sequencer #(
    parameter int DATA_W = 32,
    parameter int NREG   = 16,
    parameter int OPC_W  = 5
) (
    input  logic              Clock,
    input  logic              Clear,
    input  logic              start,
    input  logic              mem_done,
    input  logic [DATA_W-1:0] IR,
    output logic              PCout,
    output logic              Zhiout,
    output logic              Zlowout,
    output logic              MDRout,
    output logic              MARin,
    output logic              Zin,
    output logic              PCin,
    output logic              MDRin,
    output logic              IRin,
    output logic              Yin,
    output logic              HIin,
    output logic              LOin,
    output logic              IncPC,
    output logic              Read,
    output logic [NREG-1:0]   Rout_sel,
    output logic [NREG-1:0]   Rin_sel,
    output logic [OPC_W-1:0]  alu_op,
    output logic              busy,
    output logic              done,
    output logic              illegal
);

    typedef enum logic [2:0] {IDLE, T0, T1, T2, T3, T4, T5, T6} state_t;

    localparam int RA_HI = DATA_W - OPC_W - 1;
    localparam logic [4:0] NREG_L = 5'(NREG);
    localparam logic [NREG-1:0] ONE = NREG'(1);
    localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(3);
    localparam logic [OPC_W-1:0] OP_SUB = OPC_W'(4);
    localparam logic [OPC_W-1:0] OP_AND = OPC_W'(5);
    localparam logic [OPC_W-1:0] OP_OR  = OPC_W'(6);
    localparam logic [OPC_W-1:0] OP_MUL = OPC_W'(15);
    localparam logic [OPC_W-1:0] OP_DIV = OPC_W'(16);

    state_t           state;
    state_t           finish_state;
    logic             t1_wait;
    logic [OPC_W-1:0] op_q;
    logic [3:0]       ra_q;
    logic [3:0]       rc_q;
    logic             md_q;

    logic [OPC_W-1:0] opc;
    logic [3:0]       ra;
    logic [3:0]       rb;
    logic [3:0]       rc;
    logic             is_3reg;
    logic             is_muldiv;
    logic             legal;
    logic             unused_ir;

    assign opc = IR[DATA_W-1 -: OPC_W];
    assign ra  = IR[RA_HI -: 4];
    assign rb  = IR[RA_HI-4 -: 4];
    assign rc  = IR[RA_HI-8 -: 4];
    assign unused_ir = ^IR[RA_HI-12:0];

    // MUL/DIV ignore Ra, so only the 3-register ops need it in range
    assign is_3reg   = (opc == OP_ADD) || (opc == OP_SUB) || (opc == OP_AND) || (opc == OP_OR);
    assign is_muldiv = (opc == OP_MUL) || (opc == OP_DIV);
    assign legal = (is_3reg || is_muldiv)
                && ({1'b0, rb} < NREG_L) && ({1'b0, rc} < NREG_L)
                && (is_muldiv || ({1'b0, ra} < NREG_L));

`ifdef SEQ_AUTOFETCH_EN
    assign finish_state = start ? T0 : IDLE;
`else
    assign finish_state = IDLE;
`endif

    always_ff @(posedge Clock) begin
        if (Clear) begin
            state   <= IDLE;
            done    <= 1'b0;
            illegal <= 1'b0;
            t1_wait <= 1'b0;
            op_q    <= '0;
            ra_q    <= '0;
            rc_q    <= '0;
            md_q    <= 1'b0;
        end else begin
            done    <= 1'b0;
            illegal <= 1'b0;
            t1_wait <= 1'b0;
            case (state)
                IDLE: if (start) state <= T0;
                T0:   state <= T1;
                T1: begin
                    if (mem_done) state <= T2;
                    else          t1_wait <= 1'b1;
                end
                T2:   state <= T3;
                T3: begin
                    if (legal) begin
                        op_q  <= opc;
                        ra_q  <= ra;
                        rc_q  <= rc;
                        md_q  <= is_muldiv;
                        state <= T4;
                    end else begin
                        illegal <= 1'b1;
                        state   <= IDLE;
                    end
                end
                T4:   state <= T5;
                T5: begin
                    if (md_q) begin
                        state <= T6;
                    end else begin
                        done  <= 1'b1;
                        state <= finish_state;
                    end
                end
                T6: begin
                    done  <= 1'b1;
                    state <= finish_state;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // PCin is suppressed on memory wait cycles so the PC advances exactly once
    always_comb begin
        PCout    = 1'b0;
        Zhiout   = 1'b0;
        Zlowout  = 1'b0;
        MDRout   = 1'b0;
        MARin    = 1'b0;
        Zin      = 1'b0;
        PCin     = 1'b0;
        MDRin    = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        IncPC    = 1'b0;
        Read     = 1'b0;
        Rout_sel = '0;
        Rin_sel  = '0;
        alu_op   = '0;
        busy     = (state != IDLE);
        case (state)
            T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            T1: begin
                Zlowout = 1'b1;
                PCin    = !t1_wait;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            T3: begin
                if (legal) begin
                    Rout_sel = ONE << rb;
                    Yin      = 1'b1;
                end
            end
            T4: begin
                Rout_sel = ONE << rc_q;
                Zin      = 1'b1;
                alu_op   = op_q;
            end
            T5: begin
                Zlowout = 1'b1;
                if (md_q) LOin = 1'b1;
                else      Rin_sel = ONE << ra_q;
            end
            T6: begin
                Zhiout = 1'b1;
                HIin   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Self-checking bench for alu_instr_sequencer: per-cycle scoreboard fed by a step-list model,
// directed scenarios with literal expectations, then randomized instructions and memory waits.
module tb_alu_instr_sequencer;

    typedef struct packed {
        logic        pcout, zhiout, zlowout, mdrout, marin, zin, pcin;
        logic        mdrin, irin, yin, hiin, loin, incpc, read;
        logic [15:0] rout;
        logic [15:0] rin;
        logic [4:0]  alu_op;
        logic        busy, done, illegal;
    } outs_t;

    logic        Clock = 1'b0;
    logic        Clear = 1'b1;
    logic        start = 1'b0;
    logic        mem_done = 1'b0;
    logic [31:0] IR = '0;
    logic PCout, Zhiout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, IncPC, Read;
    logic [15:0] Rout_sel, Rin_sel;
    logic [4:0]  alu_op;
    logic        busy, done, illegal;

    int    checks = 0;
    int    errors = 0;
    int    cycle = 0;
    outs_t expQ[$];
    outs_t model[$];
    outs_t snaps[$];
    outs_t lastSnap;

    alu_instr_sequencer dut (
        .Clock(Clock), .Clear(Clear), .start(start), .mem_done(mem_done), .IR(IR),
        .PCout(PCout), .Zhiout(Zhiout), .Zlowout(Zlowout), .MDRout(MDRout),
        .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin),
        .Yin(Yin), .HIin(HIin), .LOin(LOin), .IncPC(IncPC), .Read(Read),
        .Rout_sel(Rout_sel), .Rin_sel(Rin_sel), .alu_op(alu_op),
        .busy(busy), .done(done), .illegal(illegal)
    );

    always #5 Clock = ~Clock;

    function automatic outs_t sampleDut();
        outs_t o;
        o = '{pcout: PCout, zhiout: Zhiout, zlowout: Zlowout, mdrout: MDRout, marin: MARin,
              zin: Zin, pcin: PCin, mdrin: MDRin, irin: IRin, yin: Yin, hiin: HIin, loin: LOin,
              incpc: IncPC, read: Read, rout: Rout_sel, rin: Rin_sel, alu_op: alu_op,
              busy: busy, done: done, illegal: illegal};
        return o;
    endfunction

    // Expected output of every cycle from the start cycle through the done/illegal pulse
    function automatic void buildSeq(input logic [31:0] instr, input int waits);
        outs_t      o;
        logic [4:0] opc;
        logic [3:0] ra, rb, rc;
        logic       md;
        opc = instr[31:27];
        ra  = instr[26:23];
        rb  = instr[22:19];
        rc  = instr[18:15];
        md  = (opc == 5'd15) || (opc == 5'd16);
        model.delete();
        o = '0; model.push_back(o);
        o = '0; o.busy = 1; o.pcout = 1; o.marin = 1; o.incpc = 1; o.zin = 1; model.push_back(o);
        for (int w = 0; w <= waits; w++) begin
            o = '0; o.busy = 1; o.zlowout = 1; o.read = 1; o.mdrin = 1; o.pcin = (w == 0);
            model.push_back(o);
        end
        o = '0; o.busy = 1; o.mdrout = 1; o.irin = 1; model.push_back(o);
        if (!(opc inside {5'd3, 5'd4, 5'd5, 5'd6, 5'd15, 5'd16})) begin
            o = '0; o.busy = 1; model.push_back(o);
            o = '0; o.illegal = 1; model.push_back(o);
            return;
        end
        o = '0; o.busy = 1; o.yin = 1; o.rout = 16'(1) << rb; model.push_back(o);
        o = '0; o.busy = 1; o.zin = 1; o.rout = 16'(1) << rc; o.alu_op = opc; model.push_back(o);
        o = '0; o.busy = 1; o.zlowout = 1;
        if (md) o.loin = 1;
        else    o.rin = 16'(1) << ra;
        model.push_back(o);
        if (md) begin
            o = '0; o.busy = 1; o.zhiout = 1; o.hiin = 1; model.push_back(o);
        end
        o = '0; o.done = 1; model.push_back(o);
    endfunction

    task automatic applyStimulus(input logic st, input logic md, input logic clr,
                                 input logic [31:0] instr, input outs_t e);
        @(posedge Clock);
        #1;
        start    = st;
        mem_done = md;
        Clear    = clr;
        IR       = instr;
        expQ.push_back(e);
        @(negedge Clock);
        lastSnap = sampleDut();
    endtask

    task automatic checkOutput(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("[TB] FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    // Start is randomized in busy cycles where it must be ignored; never in the last step
    task automatic runInstr(input logic [31:0] instr, input int waits, input int clearAt,
                            output int latency);
        logic st, md;
        int   last;
        buildSeq(instr, waits);
        snaps.delete();
        latency = -1;
        last = model.size() - 1;
        for (int i = 0; i <= last; i++) begin
            st = (i == 0) ? 1'b1 : ((i < last - 1) ? 1'($urandom) : 1'b0);
            if (i >= 2 && i <= 2 + waits) md = (i == 2 + waits);
            else                          md = 1'($urandom);
            applyStimulus(st, md, (i == clearAt), instr, model[i]);
            snaps.push_back(lastSnap);
            if (lastSnap.done && latency < 0) latency = i;
            if (i == clearAt) break;
        end
        if (clearAt >= 0) applyStimulus(1'b0, 1'b0, 1'b0, instr, '0);
    endtask

    initial begin : compare
        outs_t e, got;
        forever begin
            @(negedge Clock);
            cycle++;
            if (expQ.size() > 0) begin
                e   = expQ.pop_front();
                got = sampleDut();
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("[TB] FAIL cycle_compare @%0d got %h want %h", cycle, got, e);
                end
            end
        end
    end

    initial begin : stim
        int lat, cnt, orv, idx;
        logic [31:0] rir;
        logic [4:0]  ropc;
        int legalOps[6] = '{3, 4, 5, 6, 15, 16};

        @(posedge Clock);
        applyStimulus(1'b0, 1'b0, 1'b1, '0, '0);
        checkOutput("reset_outs_zero", int'(lastSnap == '0), 1);
        checkOutput("reset_busy", int'(lastSnap.busy), 0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);

        runInstr(32'h1A920000, 0, -1, lat);
        checkOutput("add_latency", lat, 7);
        checkOutput("add_t3_rout", int'(snaps[4].rout), 'h0004);
        checkOutput("add_t4_rout", int'(snaps[5].rout), 'h0010);
        checkOutput("add_t4_aluop", int'(snaps[5].alu_op), 3);
        checkOutput("add_t5_rin", int'(snaps[6].rin), 'h0020);
        checkOutput("add_t5_zlowout", int'(snaps[6].zlowout), 1);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);

        runInstr(32'h1A920000, 3, -1, lat);
        checkOutput("wait_latency", lat, 10);
        cnt = 0;
        foreach (snaps[i]) cnt += int'(snaps[i].read && snaps[i].mdrin);
        checkOutput("wait_read_cycles", cnt, 4);
        cnt = 0;
        foreach (snaps[i]) cnt += int'(snaps[i].pcin);
        checkOutput("wait_pcin_cycles", cnt, 1);

        runInstr(32'h78120000, 0, -1, lat);
        checkOutput("mul_latency", lat, 8);
        checkOutput("mul_t5_lo", int'(snaps[6].loin && snaps[6].zlowout), 1);
        checkOutput("mul_t6_hi", int'(snaps[7].hiin && snaps[7].zhiout), 1);
        orv = 0;
        foreach (snaps[i]) orv |= int'(snaps[i].rin);
        checkOutput("mul_rin_never", orv, 0);

        runInstr(32'hF8000000, 0, -1, lat);
        checkOutput("illegal_no_done", lat, -1);
        idx = -1;
        foreach (snaps[i]) if (snaps[i].illegal && idx < 0) idx = i;
        checkOutput("illegal_pulse_idx", idx, 5);
        checkOutput("illegal_t3_yin", int'(snaps[4].yin), 0);
        cnt = 0;
        foreach (snaps[i]) cnt += int'(snaps[i].zin);
        checkOutput("illegal_zin_t0_only", cnt, 1);
        checkOutput("illegal_back_idle", int'(lastSnap.busy), 0);

        runInstr(32'h1A920000, 0, 5, lat);
        checkOutput("clear_idle_outs", int'(lastSnap == '0), 1);
        runInstr(32'h1A920000, 0, -1, lat);
        checkOutput("after_clear_latency", lat, 7);
        checkOutput("after_clear_t0_pcout", int'(snaps[1].pcout && snaps[1].marin), 1);

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 4) != 0) ropc = 5'(legalOps[$urandom_range(0, 5)]);
            else                           ropc = 5'($urandom_range(0, 31));
            rir = $urandom;
            rir[31:27] = ropc;
            runInstr(rir, int'($urandom_range(0, 3)), -1, lat);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++)
                applyStimulus(1'b0, 1'($urandom), 1'b0, $urandom, '0);
        end

        @(posedge Clock);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
